// File: rtl/fl_io_pkg.sv
// Shared widths and defaults for the buffered floating-point I/O bank.
package fl_io_pkg;

  localparam int unsigned FDEPTH_DEF = 4;

  // Float word: sign, exponent, mantissa.
  function automatic int unsigned fl_width(input int unsigned nbmant, input int unsigned nbexpo);
    return nbmant + nbexpo + 1;
  endfunction

  function automatic int unsigned addr_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fl_io_fifo.sv
// Synchronous FIFO with async active-low reset; head reads as zero while empty.
module fl_io_fifo
  import fl_io_pkg::*;
#(
  parameter int unsigned W     = 8,
  parameter int unsigned DEPTH = FDEPTH_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic [W-1:0]             i_data,
  output logic [W-1:0]             o_data_c,
  output logic                     o_full_c,
  output logic                     o_empty_c,
  output logic [$clog2(DEPTH):0]   o_count_c
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [W-1:0]  r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          w_push;
  logic          w_pop;

  assign o_full_c  = (r_count == CW'(DEPTH));
  assign o_empty_c = (r_count == '0);
  assign o_count_c = r_count;
  assign w_push    = i_push && !o_full_c;
  assign w_pop     = i_pop && !o_empty_c;
  assign o_data_c  = o_empty_c ? '0 : r_mem[r_rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end

endmodule

// File: rtl/float2int.sv
// Float to signed integer of float-word width: mantissa shifted by the signed exponent.
module float2int
  import fl_io_pkg::*;
#(
  parameter int unsigned NBMANT = 19,
  parameter int unsigned NBEXPO = 8
) (
  input  logic [fl_width(NBMANT, NBEXPO)-1:0]    i_float,
  output logic [fl_width(NBMANT, NBEXPO)-1:0]    o_int_c
);

  localparam int unsigned NBFL = fl_width(NBMANT, NBEXPO);

  logic [NBEXPO-1:0] w_exp;
  logic [NBEXPO-1:0] w_nexp;
  logic [NBFL-1:0]   w_mag;

  always_comb begin
    w_exp   = i_float[NBFL-2 -: NBEXPO];
    w_nexp  = NBEXPO'(0) - w_exp;
    w_mag   = w_exp[NBEXPO-1] ? (NBFL'(i_float[NBMANT-1:0]) >> w_nexp)
                              : (NBFL'(i_float[NBMANT-1:0]) << w_exp);
    o_int_c = i_float[NBFL-1] ? (NBFL'(0) - w_mag) : w_mag;
  end

endmodule

// File: rtl/int2float.sv
// Signed integer to float: mantissa normalised to its MSB, exponent = -shift.
module int2float
  import fl_io_pkg::*;
#(
  parameter int unsigned NBMANT = 19,
  parameter int unsigned NBEXPO = 8
) (
  input  logic [NBMANT-1:0]                      i_int,
  output logic [fl_width(NBMANT, NBEXPO)-1:0]    o_float_c
);

  localparam int unsigned LZW = $clog2(NBMANT);

  logic [NBMANT-1:0] w_mag;
  logic [NBMANT-1:0] w_norm;
  logic [LZW-1:0]    w_lz;

  // Highest set bit wins, giving the left shift that normalises the magnitude.
  always_comb begin
    w_mag = i_int[NBMANT-1] ? (~i_int + NBMANT'(1)) : i_int;
    w_lz  = '0;
    for (int k = 0; k < NBMANT; k++) begin
      if (w_mag[k]) w_lz = LZW'(NBMANT - 1 - k);
    end
    w_norm    = w_mag << w_lz;
    o_float_c = {i_int[NBMANT-1], NBEXPO'(0) - NBEXPO'(w_lz), w_norm};
  end

endmodule

// File: rtl/fl_io_bank.sv
// Buffered I/O bank between proc_fl and integer channels, with per-channel FIFOs.
// Define FL_IO_STATS_EN to enable the saturating stall-cycle counter.
module fl_io_bank
  import fl_io_pkg::*;
#(
  parameter int unsigned NBMANT = 19,
  parameter int unsigned NBEXPO = 8,
  parameter int unsigned NUIOIN = 4,
  parameter int unsigned NUIOOU = 4,
  parameter int unsigned FDEPTH = FDEPTH_DEF
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic                                       proc_req_in,
  input  logic [addr_width(NUIOIN)-1:0]              addr_in,
  output logic [fl_width(NBMANT, NBEXPO)-1:0]        proc_in_float,
  input  logic                                       proc_out_en,
  input  logic [addr_width(NUIOOU)-1:0]              addr_out,
  input  logic [fl_width(NBMANT, NBEXPO)-1:0]        proc_out_float,
  output logic                                       proc_stall,
  input  logic [NUIOIN*NBMANT-1:0]                   in_data,
  input  logic [NUIOIN-1:0]                          in_valid,
  output logic [NUIOIN-1:0]                          in_ready,
  output logic [NUIOOU*fl_width(NBMANT, NBEXPO)-1:0] out_data,
  output logic [NUIOOU-1:0]                          out_valid,
  input  logic [NUIOOU-1:0]                          out_ready,
  output logic [15:0]                                stall_cnt
);

  localparam int unsigned NBFL = fl_width(NBMANT, NBEXPO);
  localparam int unsigned AIW  = addr_width(NUIOIN);
  localparam int unsigned AOW  = addr_width(NUIOOU);
  localparam int unsigned CW   = $clog2(FDEPTH) + 1;

  logic [NBMANT-1:0]    w_in_head [NUIOIN];
  logic [NUIOIN-1:0]    w_in_full, w_in_empty, w_in_push, w_in_pop;
  logic [NUIOIN*CW-1:0] w_in_cnt;
  logic [NBFL-1:0]      w_out_head [NUIOOU];
  logic [NUIOOU-1:0]    w_out_full, w_out_empty, w_out_push, w_out_pop;
  logic [NUIOOU*CW-1:0] w_out_cnt;
  logic                 w_rd_ok, w_wr_ok, w_rd_empty, w_wr_full, w_rd_pop, w_wr_push;
  logic [NBMANT-1:0]    w_rd_head;
  logic [NBFL-1:0]      w_wr_int;
  logic                 w_unused_cnt;

  assign w_rd_ok    = (32'(addr_in) < NUIOIN);
  assign w_wr_ok    = (32'(addr_out) < NUIOOU);
  assign w_rd_empty = w_rd_ok && w_in_empty[addr_in];
  assign w_wr_full  = w_wr_ok && w_out_full[addr_out];
  assign w_rd_head  = w_rd_ok ? w_in_head[addr_in] : '0;

  // A stall on either side holds both the read and the write.
  assign proc_stall = (proc_req_in && w_rd_empty) || (proc_out_en && w_wr_full);
  assign w_rd_pop   = proc_req_in && w_rd_ok && !w_rd_empty && !proc_stall;
  assign w_wr_push  = proc_out_en && w_wr_ok && !w_wr_full && !proc_stall;

  assign in_ready     = ~w_in_full;
  assign out_valid    = ~w_out_empty;
  assign w_unused_cnt = ^{w_in_cnt, w_out_cnt};

  int2float #(.NBMANT(NBMANT), .NBEXPO(NBEXPO)) u_i2f (
    .i_int     (w_rd_head),
    .o_float_c (proc_in_float)
  );

  float2int #(.NBMANT(NBMANT), .NBEXPO(NBEXPO)) u_f2i (
    .i_float (proc_out_float),
    .o_int_c (w_wr_int)
  );

  for (genvar gi = 0; gi < NUIOIN; gi++) begin : g_in
    assign w_in_push[gi] = in_valid[gi] && !w_in_full[gi];
    assign w_in_pop[gi]  = w_rd_pop && (addr_in == AIW'(gi));
    fl_io_fifo #(.W(NBMANT), .DEPTH(FDEPTH)) u_fifo (
      .clk       (clk),
      .rst_n     (rst),
      .i_push    (w_in_push[gi]),
      .i_pop     (w_in_pop[gi]),
      .i_data    (in_data[gi*NBMANT +: NBMANT]),
      .o_data_c  (w_in_head[gi]),
      .o_full_c  (w_in_full[gi]),
      .o_empty_c (w_in_empty[gi]),
      .o_count_c (w_in_cnt[gi*CW +: CW])
    );
  end

  for (genvar gj = 0; gj < NUIOOU; gj++) begin : g_out
    assign w_out_push[gj] = w_wr_push && (addr_out == AOW'(gj));
    assign w_out_pop[gj]  = out_ready[gj] && !w_out_empty[gj];
    assign out_data[gj*NBFL +: NBFL] = w_out_head[gj];
    fl_io_fifo #(.W(NBFL), .DEPTH(FDEPTH)) u_fifo (
      .clk       (clk),
      .rst_n     (rst),
      .i_push    (w_out_push[gj]),
      .i_pop     (w_out_pop[gj]),
      .i_data    (w_wr_int),
      .o_data_c  (w_out_head[gj]),
      .o_full_c  (w_out_full[gj]),
      .o_empty_c (w_out_empty[gj]),
      .o_count_c (w_out_cnt[gj*CW +: CW])
    );
  end

`ifdef FL_IO_STATS_EN
  logic [15:0] r_stall_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_stall_cnt <= '0;
    end else if (proc_stall && (r_stall_cnt != 16'hFFFF)) begin
      r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end

  assign stall_cnt = r_stall_cnt;
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_fl_io_bank.sv
// Randomised bench for fl_io_bank against a queue-based behavioural model.
module tb_fl_io_bank;

  localparam int unsigned NBMANT = 19;
  localparam int unsigned NBEXPO = 8;
  localparam int unsigned NUIOIN = 4;
  localparam int unsigned NUIOOU = 4;
  localparam int unsigned FDEPTH = 4;
  localparam int unsigned NBFL   = NBMANT + NBEXPO + 1;

  logic                     clk;
  logic                     rst;
  logic                     proc_req_in;
  logic [1:0]               addr_in;
  logic [NBFL-1:0]          proc_in_float;
  logic                     proc_out_en;
  logic [1:0]               addr_out;
  logic [NBFL-1:0]          proc_out_float;
  logic                     proc_stall;
  logic [NUIOIN*NBMANT-1:0] in_data;
  logic [NUIOIN-1:0]        in_valid;
  logic [NUIOIN-1:0]        in_ready;
  logic [NUIOOU*NBFL-1:0]   out_data;
  logic [NUIOOU-1:0]        out_valid;
  logic [NUIOOU-1:0]        out_ready;
  logic [15:0]              stall_cnt;

  logic signed [NBMANT-1:0] in_vals [NUIOIN];

  int              q_in  [NUIOIN][$];
  logic [NBFL-1:0] q_out [NUIOOU][$];
  int              m_cnt;
  int              n_chk;
  int              n_pass;

  fl_io_bank #(
    .NBMANT(NBMANT), .NBEXPO(NBEXPO), .NUIOIN(NUIOIN), .NUIOOU(NUIOOU), .FDEPTH(FDEPTH)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .proc_req_in    (proc_req_in),
    .addr_in        (addr_in),
    .proc_in_float  (proc_in_float),
    .proc_out_en    (proc_out_en),
    .addr_out       (addr_out),
    .proc_out_float (proc_out_float),
    .proc_stall     (proc_stall),
    .in_data        (in_data),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .out_data       (out_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .stall_cnt      (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < NUIOIN; i++) in_data[i*NBMANT +: NBMANT] = in_vals[i];
  end

  // Reference conversion: value = (-1)^s * mant * 2^exp, mantissa normalised to its top bit.
  function automatic logic [NBFL-1:0] m_i2f(input int v);
    longint m;
    int e;
    logic s;
    logic [NBEXPO-1:0] eb;
    logic [NBMANT-1:0] mb;
    s = (v < 0);
    m = (v < 0) ? -longint'(v) : longint'(v);
    e = 0;
    while (m != 0 && m < (64'sd1 <<< (NBMANT - 1))) begin
      m = m * 2;
      e = e - 1;
    end
    eb = NBEXPO'(e);
    mb = NBMANT'(m);
    return {s, eb, mb};
  endfunction

  function automatic logic [NBFL-1:0] m_f2i(input logic [NBFL-1:0] f);
    longint mag;
    int e;
    logic [NBEXPO-1:0] eb;
    eb  = f[NBFL-2 -: NBEXPO];
    e   = int'($signed(eb));
    mag = longint'(f[NBMANT-1:0]);
    if (e >= 0) mag = mag * (64'sd1 <<< e);
    else if (e > -40) mag = mag / (64'sd1 <<< (-e));
    else mag = 0;
    if (f[NBFL-1]) mag = -mag;
    return NBFL'(mag);
  endfunction

  function automatic logic [NBFL-1:0] rand_float();
    logic s;
    int e;
    s = 1'($urandom_range(1));
    e = int'($urandom_range(32)) - 24;
    return {s, NBEXPO'(e), NBMANT'($urandom)};
  endfunction

  function automatic logic m_stall();
    logic rs, ws;
    rs = proc_req_in && (int'(addr_in) < NUIOIN) && (q_in[addr_in].size() == 0);
    ws = proc_out_en && (int'(addr_out) < NUIOOU) && (q_out[addr_out].size() == FDEPTH);
    return rs || ws;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < NUIOIN; i++) q_in[i].delete();
    for (int j = 0; j < NUIOOU; j++) q_out[j].delete();
    m_cnt = 0;
  endtask

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    else n_pass++;
  endtask

  // Sample just after the falling edge and compare every output with the model.
  task automatic sample();
    logic [NUIOIN-1:0] e_rdy;
    logic [NUIOOU-1:0] e_vld;
    logic [NUIOOU*NBFL-1:0] e_dat;
    int head;
    #1;
    if (!rst) model_clear();
    for (int i = 0; i < NUIOIN; i++) e_rdy[i] = (q_in[i].size() < FDEPTH);
    for (int j = 0; j < NUIOOU; j++) begin
      e_vld[j] = (q_out[j].size() > 0);
      e_dat[j*NBFL +: NBFL] = e_vld[j] ? q_out[j][0] : '0;
    end
    head = (int'(addr_in) < NUIOIN && q_in[addr_in].size() > 0) ? q_in[addr_in][0] : 0;
    chk("in_ready", 128'(in_ready), 128'(e_rdy));
    chk("out_valid", 128'(out_valid), 128'(e_vld));
    chk("out_data", 128'(out_data), 128'(e_dat));
    chk("proc_stall", 128'(proc_stall), 128'(m_stall()));
    chk("proc_in_float", 128'(proc_in_float), 128'(m_i2f(head)));
`ifdef FL_IO_STATS_EN
    chk("stall_cnt", 128'(stall_cnt), 128'(m_cnt));
`else
    chk("stall_cnt", 128'(stall_cnt), 128'(0));
`endif
  endtask

  // Apply this cycle's inputs to the model, then move to the next falling edge.
  task automatic advance();
    logic st, rd, wr;
    logic [NUIOIN-1:0] acc;
    logic [NUIOOU-1:0] opop;
    logic [NBFL-1:0] wv;
    if (!rst) begin
      model_clear();
    end else begin
      st = m_stall();
      for (int i = 0; i < NUIOIN; i++) acc[i] = in_valid[i] && (q_in[i].size() < FDEPTH);
      for (int j = 0; j < NUIOOU; j++) opop[j] = out_ready[j] && (q_out[j].size() > 0);
      rd = proc_req_in && (int'(addr_in) < NUIOIN) && (q_in[addr_in].size() > 0) && !st;
      wr = proc_out_en && (int'(addr_out) < NUIOOU) && (q_out[addr_out].size() < FDEPTH) && !st;
      wv = m_f2i(proc_out_float);
      if (rd) void'(q_in[addr_in].pop_front());
      for (int i = 0; i < NUIOIN; i++) if (acc[i]) q_in[i].push_back(int'(in_vals[i]));
      for (int j = 0; j < NUIOOU; j++) if (opop[j]) void'(q_out[j].pop_front());
      if (wr) q_out[addr_out].push_back(wv);
      if (st && m_cnt < 65535) m_cnt++;
    end
    @(negedge clk);
  endtask

  initial begin
    n_chk = 0; n_pass = 0; m_cnt = 0;
    rst = 1'b0; proc_req_in = 1'b0; addr_in = '0; proc_out_en = 1'b0; addr_out = '0;
    proc_out_float = '0; in_valid = '0; out_ready = '0;
    for (int i = 0; i < NUIOIN; i++) in_vals[i] = '0;
    @(negedge clk);

    sample();
    chk("rst_in_ready", 128'(in_ready), 128'(4'hF));
    chk("rst_out_valid", 128'(out_valid), 128'(0));
    chk("rst_float", 128'(proc_in_float), 128'(0));
    advance();
    rst = 1'b1;
    sample(); advance();

    // Round trip 5 and -7 through input ch1 and output ch2.
    in_valid = 4'b0010; in_vals[1] = 19'sd5;
    sample(); advance();
    in_vals[1] = -19'sd7;
    sample(); advance();
    in_valid = '0; proc_req_in = 1'b1; addr_in = 2'd1;
    sample();
    chk("rt_read5", 128'(proc_in_float), 128'(28'h7850000));
    chk("rt_no_stall", 128'(proc_stall), 128'(0));
    advance();
    proc_out_en = 1'b1; addr_out = 2'd2; proc_out_float = 28'h7850000;
    sample();
    chk("rt_read_m7", 128'(proc_in_float), 128'(28'hF870000));
    advance();
    proc_req_in = 1'b0; proc_out_float = 28'hF870000;
    sample();
    chk("rt_valid_next", 128'(out_valid[2]), 128'(1));
    chk("rt_out5", 128'(out_data[2*NBFL +: NBFL]), 128'(28'h5));
    advance();
    proc_out_en = 1'b0; out_ready = 4'b0100;
    sample(); chk("rt_head5", 128'(out_data[2*NBFL +: NBFL]), 128'(28'h5)); advance();
    sample(); chk("rt_out_m7", 128'(out_data[2*NBFL +: NBFL]), 128'(28'hFFFFFF9)); advance();
    out_ready = '0;
    sample(); chk("rt_drained", 128'(out_valid[2]), 128'(0)); advance();

    // Empty read on ch3 for four cycles, sample pushed in the fourth.
    proc_req_in = 1'b1; addr_in = 2'd3;
    for (int k = 0; k < 4; k++) begin
      if (k == 3) begin in_valid = 4'b1000; in_vals[3] = 19'sd123; end
      sample(); chk("empty_stall", 128'(proc_stall), 128'(1)); advance();
    end
    in_valid = '0;
    sample();
    chk("empty_released", 128'(proc_stall), 128'(0));
    chk("empty_read123", 128'(proc_in_float), 128'(28'h7A7B000));
    advance();
    proc_req_in = 1'b0;
    sample(); advance();

    // Output ch0 fills with out_ready low; fifth write stalls until a pop.
    proc_out_en = 1'b1; addr_out = 2'd0;
    for (int k = 0; k < 5; k++) begin
      proc_out_float = rand_float();
      sample(); chk("full_stall", 128'(proc_stall), 128'(k == 4)); advance();
    end
    out_ready = 4'b0001;
    sample(); chk("full_stall_held", 128'(proc_stall), 128'(1)); advance();
    sample(); chk("full_write_done", 128'(proc_stall), 128'(0)); advance();
    proc_out_en = 1'b0;
    for (int k = 0; k < 5; k++) begin sample(); advance(); end
    out_ready = '0;

    // Continuous push/pop on input ch2, values 0..9.
    proc_req_in = 1'b1; addr_in = 2'd2;
    for (int k = 0; k < 10; k++) begin
      in_valid = 4'b0100; in_vals[2] = NBMANT'(k);
      sample(); chk("wrap_ready", 128'(in_ready[2]), 128'(1)); advance();
    end
    in_valid = '0;
    sample(); chk("wrap_last9", 128'(proc_in_float), 128'(m_i2f(9))); advance();
    proc_req_in = 1'b0;

    // Stall counter over seven stall cycles from reset.
    rst = 1'b0; sample(); advance(); rst = 1'b1;
    proc_req_in = 1'b1; addr_in = 2'd0;
    for (int k = 0; k < 7; k++) begin sample(); advance(); end
    proc_req_in = 1'b0;
    sample();
`ifdef FL_IO_STATS_EN
    chk("stall_cnt7", 128'(stall_cnt), 128'(7));
`else
    chk("stall_cnt_off", 128'(stall_cnt), 128'(0));
`endif
    advance();

    // Reset mid-stream with three words queued on input ch0.
    in_valid = 4'b0001;
    for (int k = 0; k < 3; k++) begin in_vals[0] = NBMANT'($urandom); sample(); advance(); end
    in_valid = '0; proc_out_en = 1'b1; addr_out = 2'd1; proc_out_float = rand_float();
    sample(); advance();
    proc_out_en = 1'b0; rst = 1'b0;
    sample();
    chk("rst_mid_ready", 128'(in_ready), 128'(4'hF));
    chk("rst_mid_valid", 128'(out_valid), 128'(0));
    advance();
    rst = 1'b1; proc_req_in = 1'b1; addr_in = 2'd0;
    sample(); chk("rst_mid_stall", 128'(proc_stall), 128'(1)); advance();

    // Random traffic.
    for (int c = 0; c < 2000; c++) begin
      rst         = ($urandom_range(499) != 0);
      in_valid    = NUIOIN'($urandom);
      for (int i = 0; i < NUIOIN; i++) in_vals[i] = NBMANT'($urandom);
      proc_req_in = ($urandom_range(1) == 1);
      addr_in     = 2'($urandom);
      proc_out_en = ($urandom_range(9) < 4);
      addr_out    = 2'($urandom);
      proc_out_float = rand_float();
      out_ready   = NUIOOU'($urandom) | NUIOOU'($urandom);
      sample(); advance();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
